mem_read_skew_ctrl: RTL
=======================

// Module: mem_read_skew_ctrl
// PURPOSE
//   Read sequencer that drives memArr's per-bank rd_en/rd_addr to stream a block of
//   rows out of the banks in diagonal (skewed) order: bank k reads each row k cycles
//   after bank 0. This is the wavefront the systolic array consumes. It sits directly
//   upstream of memArr and emits data_valid aligned with memArr's rd_data.
// PARAMETERS
//   WIDTH_HEIGHT   4   number of banks/lanes (= systolic array edge)
//   ADDR_W         8   per-bank address width (bits)
//   RD_LATENCY     1   memArr read latency in cycles (rd_en -> rd_data valid)
// PORTS
//   clk         in   1                  single clock, rising edge
//   reset       in   1                  synchronous, active-high
//   start       in   1                  1-cycle request; sampled only in IDLE
//   base_addr   in   ADDR_W             first row address (latched on start)
//   num_rows    in   ADDR_W             rows to read, 0..255 (latched on start)
//   busy        out  1                  sequence in progress
//   done        out  1                  1-cycle pulse on the final data_valid beat
//   rd_en       out  WIDTH_HEIGHT       to memArr rd_en, bit k = bank k
//   rd_addr     out  WIDTH_HEIGHT*ADDR_W to memArr rd_addr, bank k in [k*ADDR_W +: ADDR_W]
//   data_valid  out  WIDTH_HEIGHT       rd_en delayed RD_LATENCY, qualifies memArr rd_data
// BEHAVIOUR
//   - All outputs are registered. Reset (sync) forces busy/done/rd_en/rd_addr/data_valid
//     to 0 at the next edge, clears all delay stages and the row counter, and sets state
//     to IDLE. Reset mid-sequence aborts the sequence with no done pulse.
//   - FSM: IDLE -> ISSUE -> DRAIN -> IDLE.
//     IDLE: start && num_rows!=0 -> latch base/num_rows -> ISSUE.
//           start && num_rows==0 -> done pulses next cycle; busy and rd_en stay 0.
//     ISSUE: lane 0 issues base, base+1, ..., base+num_rows-1 on consecutive cycles.
//            Lane k issues the same sequence delayed k cycles (shift of lane 0's en/addr).
//            Leave ISSUE when the last lane's last read is issued.
//     DRAIN: wait RD_LATENCY cycles for the final data_valid, then -> IDLE.
//   - Timing (start sampled at edge of cycle 0, N=num_rows, W=WIDTH_HEIGHT):
//     rd_en[k] high for cycles 1+k .. N+k; busy high for cycles 1 .. N+W-1+RD_LATENCY;
//     done high only in cycle N+W-1+RD_LATENCY, coincident with the last data_valid[W-1].
//   - Addresses are computed mod 2^ADDR_W (0xFF+1 -> 0x00). rd_addr lane is 0 when its
//     rd_en is 0.
//   - start while busy is ignored, with no effect on latched values. start in the same
//     cycle as reset is ignored.
//   - rd_en never asserts for a lane outside its window, and no lane writes (wr_en is
//     owned elsewhere).
// STRUCTURE
//   - Shared header tpu_defines.vh: BYTE_W=8, MEM_RD_LATENCY=1, state encodings
//     ST_IDLE/ST_ISSUE/ST_DRAIN.
//   - Sub-module skew_delay_line (DEPTH, DATA_W): a registered shift chain with sync
//     clear. Instantiate it once for {en,addr} lane skew (depth W-1, taps per lane), and
//     once for the rd_en -> data_valid delay (depth RD_LATENCY).
//   - Top level: FSM, row counter, lane-0 address generator.
// TESTING (W=4, RD_LATENCY=1)
//   1 base=0x00,N=4: rd_en 0001,0011,0111,1111,1110,1100,1000 in cycles 1..7;
//     rd_addr in cycle 4 = 32'h0001_0203; done only in cycle 8; busy cycles 1..8.
//   2 wrap: base=0xFE,N=3 -> lane0 addr FE,FF,00 in cycles 1..3; lane3 same in cycles 4..6.
//   3 N=0: start -> done=1 in cycle 1; rd_en, busy, data_valid stay 0.
//   4 start re-pulsed with base=0x40 in cycle 3 of test 1 -> ignored; sequence and
//     addresses are identical to test 1.
//   5 reset in cycle 3 of test 1 -> cycle 4: all outputs 0, IDLE, no done. A fresh start
//     then reproduces test 1 exactly.
//   6 with memArr (bank k row r = 4r+k), base=0,N=4: in the cycle data_valid[k] is high
//     for row r, rd_data[8k+:8] = 4r+k.

Source files
------------

// File: rtl/mem_read_skew_ctrl_pkg.sv
// Shared definitions for the skewed memory read sequencer.
package mem_read_skew_ctrl_pkg;

    localparam int BYTE_W         = 8;
    localparam int MEM_RD_LATENCY = 1;

    // Sequencer states: IDLE waits for start, ISSUE streams reads on all lanes,
    // DRAIN waits out the memory read latency for the final beat.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/mem_read_skew_ctrl_skew_delay_line.sv
// Registered shift chain with synchronous clear. Tap j carries din delayed
// by j+1 cycles, packed as taps[j*DATA_W +: DATA_W]. DEPTH must be >= 1.
module skew_delay_line #(
    parameter int DEPTH  = 3,
    parameter int DATA_W = 9
) (
    input  logic                    clk,
    input  logic                    clear,
    input  logic [DATA_W-1:0]       din,
    output logic [DEPTH*DATA_W-1:0] taps
);

    // Shift din one stage per cycle; clear empties every stage.
    always_ff @(posedge clk) begin
        if (clear) begin
            taps <= '0;
        end else begin
            for (int j = DEPTH - 1; j > 0; j--) begin
                taps[j*DATA_W +: DATA_W] <= taps[(j-1)*DATA_W +: DATA_W];
            end
            taps[0 +: DATA_W] <= din;
        end
    end

endmodule

// File: rtl/mem_read_skew_ctrl.sv
// Skewed read sequencer: lane 0 streams base..base+N-1, lane k repeats the
// same stream k cycles later, and data_valid follows rd_en by the memory
// read latency. WIDTH_HEIGHT must be >= 2 and RD_LATENCY >= 1.
module mem_read_skew_ctrl
    import mem_read_skew_ctrl_pkg::*;
#(
    parameter int WIDTH_HEIGHT = 4,
    parameter int ADDR_W       = BYTE_W,
    parameter int RD_LATENCY   = MEM_RD_LATENCY
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [ADDR_W-1:0]              base_addr,
    input  logic [ADDR_W-1:0]              num_rows,
    output logic                           busy,
    output logic                           done,
    output logic [WIDTH_HEIGHT-1:0]        rd_en,
    output logic [WIDTH_HEIGHT*ADDR_W-1:0] rd_addr,
    output logic [WIDTH_HEIGHT-1:0]        data_valid
);

    localparam int LANE_W = ADDR_W + 1;
    localparam int CNT_W  = ADDR_W + $clog2(WIDTH_HEIGHT + RD_LATENCY) + 1;
    // ISSUE lasts N+W-1 cycles; the counter is loaded with the cycles left after the first.
    localparam logic [CNT_W-1:0] ISSUE_EXTRA = CNT_W'(WIDTH_HEIGHT - 2);
    localparam logic [CNT_W-1:0] DRAIN_LOAD  = CNT_W'(RD_LATENCY - 1);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [ADDR_W-1:0]  rows_left, rows_left_nxt;
    logic               en0, en0_nxt;
    logic [ADDR_W-1:0]  addr0, addr0_nxt;
    logic               busy_nxt, done_nxt;

    logic [(WIDTH_HEIGHT-1)*LANE_W-1:0]    skew_taps;
    logic [RD_LATENCY*WIDTH_HEIGHT-1:0]    dv_taps;

    // Next-state, lane-0 address generation, row and phase counters.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        rows_left_nxt = rows_left;
        en0_nxt       = 1'b0;
        addr0_nxt     = '0;
        done_nxt      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (num_rows != '0) begin
                        state_nxt     = ST_ISSUE;
                        cnt_nxt       = CNT_W'(num_rows) + ISSUE_EXTRA;
                        rows_left_nxt = num_rows - ADDR_W'(1);
                        en0_nxt       = 1'b1;
                        addr0_nxt     = base_addr;
                    end else begin
                        // Empty request completes immediately without touching memory.
                        done_nxt = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                if (rows_left != '0) begin
                    en0_nxt       = 1'b1;
                    addr0_nxt     = addr0 + ADDR_W'(1);
                    rows_left_nxt = rows_left - ADDR_W'(1);
                end
                if (cnt == '0) begin
                    state_nxt = ST_DRAIN;
                    cnt_nxt   = DRAIN_LOAD;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            ST_DRAIN: begin
                if (cnt == '0) begin
                    state_nxt = ST_IDLE;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
        // The last DRAIN cycle carries the final data_valid beat.
        if (state_nxt == ST_DRAIN && cnt_nxt == '0) begin
            done_nxt = 1'b1;
        end
        busy_nxt = (state_nxt != ST_IDLE);
    end

    // State, counters and lane-0 output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            rows_left <= '0;
            en0       <= 1'b0;
            addr0     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            rows_left <= rows_left_nxt;
            en0       <= en0_nxt;
            addr0     <= addr0_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
        end
    end

    // Lanes 1..W-1 are lane 0's {en, addr} delayed by their lane index.
    skew_delay_line #(
        .DEPTH  (WIDTH_HEIGHT - 1),
        .DATA_W (LANE_W)
    ) u_lane_skew (
        .clk   (clk),
        .clear (reset),
        .din   ({en0, addr0}),
        .taps  (skew_taps)
    );

    // Assemble the per-bank read enables and addresses from the skew taps.
    always_comb begin
        rd_en   = '0;
        rd_addr = '0;
        rd_en[0]             = en0;
        rd_addr[0 +: ADDR_W] = addr0;
        for (int k = 1; k < WIDTH_HEIGHT; k++) begin
            rd_en[k]                  = skew_taps[(k-1)*LANE_W + ADDR_W];
            rd_addr[k*ADDR_W +: ADDR_W] = skew_taps[(k-1)*LANE_W +: ADDR_W];
        end
    end

    // data_valid tracks rd_en through the memory read latency.
    skew_delay_line #(
        .DEPTH  (RD_LATENCY),
        .DATA_W (WIDTH_HEIGHT)
    ) u_valid_delay (
        .clk   (clk),
        .clear (reset),
        .din   (rd_en),
        .taps  (dv_taps)
    );

    assign data_valid = dv_taps[(RD_LATENCY-1)*WIDTH_HEIGHT +: WIDTH_HEIGHT];

endmodule
